// File: rtl/fb_line_scheduler.sv
// Framebuffer line prefetch scheduler: fetches the next active line into the
// idle half of a ping-pong line buffer during hblank, swaps halves at line end,
// and hands spare memory cycles to a lower-priority pixel writer.
// Ports: clk_pix/rst; sx/sy beam position; wr_* writer valid/ready port;
//   mem_* single-port memory command and read return; lb_* line buffer write;
//   disp_bank scanout half; underrun sticky late-fetch flag.
module fb_line_scheduler #(
  parameter int H_RES = 800,
  parameter int V_RES = 525,
  parameter int X_RES = 640,
  parameter int Y_RES = 480,
  parameter int DW    = 16,
  parameter int AW    = 19
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic [9:0]    sx,
  input  logic [9:0]    sy,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [9:0]    lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          disp_bank,
  output logic          underrun
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [9:0]    issue_cnt;
  logic [9:0]    rcv_cnt;
  logic [9:0]    rcv_next;
  logic [AW-1:0] base;
  logic [AW-1:0] base_nx;
  logic [AW-1:0] ny_w;
  logic [9:0]    next_y;
  logic          needed;
  logic          fetch_start;
  logic          swap;
  logic          busy;
  logic          rcv_inc;

  assign next_y = (sy == 10'(V_RES - 1)) ? 10'd0 : sy + 10'd1;
  assign needed = next_y < 10'(Y_RES);
  assign fetch_start = (sx == 10'(X_RES)) && needed;
  assign swap = (sx == 10'(H_RES - 1)) && needed;
  assign busy = (state == FETCH) || (state == WAIT);
  assign ny_w = AW'(next_y);

  generate
    if (X_RES == 640) begin : g_shift
      assign base_nx = (ny_w << 9) + (ny_w << 7);
    end else begin : g_mul
      assign base_nx = ny_w * AW'(X_RES);
    end
  endgenerate

  // returns are dropped in IDLE so stale data after reset never counts
  assign rcv_inc = mem_rvalid && (state != IDLE);
  assign rcv_next = rcv_cnt + {9'd0, rcv_inc};

  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lb_we     = 1'b0;
    lb_bank   = 1'b0;
    lb_addr   = '0;
    lb_wdata  = '0;
    unique case (state)
      IDLE: begin
        wr_ready = mem_ready && !fetch_start;
        // no write command in the trigger cycle: it would reach
        // memory without the writer seeing a handshake
        if (wr_valid && !fetch_start) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
        if (fetch_start) state_nx = FETCH;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = base + AW'(issue_cnt);
        if (mem_ready && issue_cnt == 10'(X_RES - 1))
          state_nx = WAIT;
      end
      WAIT: begin
        if (rcv_next == 10'(X_RES)) state_nx = IDLE;
      end
      DRAIN: begin
        if (rcv_next == issue_cnt) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (swap && busy) state_nx = DRAIN;
    if (busy && mem_rvalid) begin
      lb_we    = 1'b1;
      lb_bank  = ~disp_bank;
      lb_addr  = rcv_cnt;
      lb_wdata = mem_rdata;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      base      <= '0;
      disp_bank <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && fetch_start) begin
        base      <= base_nx;
        issue_cnt <= '0;
        rcv_cnt   <= '0;
      end else begin
        if (state == FETCH && mem_ready)
          issue_cnt <= issue_cnt + 10'd1;
        if (rcv_inc) rcv_cnt <= rcv_next;
      end
      if (swap) begin
        disp_bank <= ~disp_bank;
        if (busy) underrun <= 1'b1;
      end
      if (fetch_start && state == DRAIN) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_line_scheduler.sv
// Bench for fb_line_scheduler: drives beam position, a latency-2 memory and a
// sequential pixel writer; each scenario compares logged traffic to arithmetic.
module tb_fb_line_scheduler;

  logic        clk_pix = 1'b0;
  logic        rst;
  logic [9:0]  sx, sy;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        lb_we, lb_bank, disp_bank, underrun;
  logic [9:0]  lb_addr;
  logic [15:0] lb_wdata;

  fb_line_scheduler dut (
    .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .disp_bank(disp_bank), .underrun(underrun)
  );

  always #5 clk_pix = ~clk_pix;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wseq = 0;
  int t_trig = 0;
  int t_done = 0;
  int lb_at_swap = 0;
  int rdy_mode = 0;
  int wv_mode = 0;
  bit wv_pend = 0;
  bit exp_disp = 0;
  bit exp_und = 0;

  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [18:0] p1_a = '0, p2_a = '0;
  logic [18:0] rd_q[$];
  logic [26:0] lbw_q[$];
  logic [34:0] wr_q[$];

  function automatic logic [15:0] rd_fn(input logic [18:0] a);
    return 16'((int'(a) * 13) ^ 32'h1357);
  endfunction

  function automatic logic [18:0] wa_fn(input int s);
    return 19'(s * 3 + 1000);
  endfunction

  function automatic logic [15:0] wd_fn(input int s);
    return 16'(s * 40503 + 7);
  endfunction

  function automatic bit needed(input int y);
    int ny;
    ny = (y == 524) ? 0 : y + 1;
    return ny < 480;
  endfunction

  task automatic clear();
    rd_q.delete();
    lbw_q.delete();
    wr_q.delete();
  endtask

  task automatic step();
    logic        nv;
    logic [18:0] na;
    nv = 1'b0;
    na = '0;
    case (rdy_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 3) != 0);
      2: mem_ready = ($urandom_range(0, 7) == 0);
      default: mem_ready = 1'b0;
    endcase
    case (wv_mode)
      0: wr_valid = 1'b0;
      1: wr_valid = 1'b1;
      default: if (!wv_pend) wr_valid = 1'($urandom_range(0, 1));
    endcase
    mem_rvalid = p2_v;
    mem_rdata = p2_v ? rd_fn(p2_a) : 16'd0;
    wr_addr = wa_fn(wseq);
    wr_data = wd_fn(wseq);
    #1;
    if (mem_req && mem_ready) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      else begin
        rd_q.push_back(mem_addr);
        nv = 1'b1;
        na = mem_addr;
      end
    end
    if (lb_we) begin
      lbw_q.push_back({lb_bank, lb_addr, lb_wdata});
      if (lbw_q.size() == 640) t_done = cyc;
    end
    if (sx == 10'd640) t_trig = cyc;
    if (sx == 10'd799) lb_at_swap = lbw_q.size();
    wv_pend = wr_valid && !wr_ready;
    if (wr_valid && wr_ready) wseq++;
    @(posedge clk_pix);
    p2_v = p1_v;
    p2_a = p1_a;
    p1_v = nv;
    p1_a = na;
    cyc++;
    @(negedge clk_pix);
  endtask

  // hold parks sx at 700 until the line buffer has seen lb_target writes
  task automatic run_line(input int y, input bit hold, input int lb_target);
    int b;
    sy = 10'(y);
    for (int x = 636; x < 800; x++) begin
      sx = 10'(x);
      step();
      if (hold && x == 700) begin
        b = 0;
        while (lbw_q.size() < lb_target && b < 3000) begin
          step();
          b++;
        end
        checks++;
        if (b >= 3000) begin
          errors++;
          $display("FAIL fetch_timeout line %0d got %0d lb writes want %0d",
                   y, lbw_q.size(), lb_target);
        end
      end
    end
    sx = 10'd0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sx = 10'd0;
    sy = 10'd0;
    rdy_mode = 3;
    wv_mode = 0;
    step();
    step();
    rst = 1'b0;
    step();
    exp_disp = 0;
    exp_und = 0;
    checks++;
    if ({mem_req, mem_we, wr_ready, lb_we, lb_bank} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
               {mem_req, mem_we, wr_ready, lb_we, lb_bank});
    end
    checks++;
    if ({mem_addr, mem_wdata, lb_addr, lb_wdata} !== 61'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {mem_addr, mem_wdata, lb_addr, lb_wdata});
    end
    checks++;
    if ({disp_bank, underrun} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00", {disp_bank, underrun});
    end
  endtask

  task automatic test_fetch(input int y, input int rm, input int wm);
    int base;
    int w0;
    bit bank;
    clear();
    rdy_mode = rm;
    wv_mode = wm;
    base = ((y == 524) ? 0 : y + 1) * 640;
    bank = !exp_disp;
    w0 = wseq;
    run_line(y, 1'b1, 640);
    if (needed(y)) exp_disp = !exp_disp;
    checks++;
    if (rd_q.size() != 640) begin
      errors++;
      $display("FAIL fetch_count y=%0d got %0d want 640", y, rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== 19'(base + i)) begin
        errors++;
        $display("FAIL fetch_addr y=%0d i=%0d got %0d want %0d",
                 y, i, rd_q[i], base + i);
      end
    end
    checks++;
    if (lbw_q.size() != 640) begin
      errors++;
      $display("FAIL lb_count y=%0d got %0d want 640", y, lbw_q.size());
    end
    for (int i = 0; i < lbw_q.size(); i++) begin
      checks++;
      if (lbw_q[i] !== {bank, 10'(i), rd_fn(19'(base + i))}) begin
        errors++;
        $display("FAIL lb_write y=%0d i=%0d got %h want %h", y, i,
                 lbw_q[i], {bank, 10'(i), rd_fn(19'(base + i))});
      end
    end
    checks++;
    if (wr_q.size() != wseq - w0) begin
      errors++;
      $display("FAIL wr_count y=%0d got %0d want %0d",
               y, wr_q.size(), wseq - w0);
    end
    for (int i = 0; i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== {wa_fn(w0 + i), wd_fn(w0 + i)}) begin
        errors++;
        $display("FAIL wr_order y=%0d i=%0d got %h want %h", y, i,
                 wr_q[i], {wa_fn(w0 + i), wd_fn(w0 + i)});
      end
    end
    checks++;
    if ({disp_bank, underrun} !== {exp_disp, exp_und}) begin
      errors++;
      $display("FAIL fetch_flags y=%0d got %b want %b", y,
               {disp_bank, underrun}, {exp_disp, exp_und});
    end
  endtask

  task automatic test_blank();
    int c0;
    int w0;
    int ys[3];
    clear();
    rdy_mode = 0;
    wv_mode = 1;
    ys[0] = 479;
    ys[1] = $urandom_range(480, 522);
    ys[2] = 523;
    c0 = cyc;
    w0 = wseq;
    for (int k = 0; k < 3; k++) run_line(ys[k], 1'b0, 0);
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL blank_reads got %0d want 0", rd_q.size());
    end
    checks++;
    if (disp_bank !== exp_disp) begin
      errors++;
      $display("FAIL blank_disp got %b want %b", disp_bank, exp_disp);
    end
    checks++;
    if (wseq - w0 != cyc - c0) begin
      errors++;
      $display("FAIL blank_grants got %0d want %0d", wseq - w0, cyc - c0);
    end
    checks++;
    if (wr_q.size() != cyc - c0) begin
      errors++;
      $display("FAIL blank_writes got %0d want %0d", wr_q.size(), cyc - c0);
    end
    for (int i = 0; i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i][34:16] !== wa_fn(w0 + i)) begin
        errors++;
        $display("FAIL blank_wr_addr i=%0d got %0d want %0d",
                 i, wr_q[i][34:16], wa_fn(w0 + i));
      end
    end
  endtask

  task automatic test_writer_hold();
    int c0;
    int w0;
    int win;
    clear();
    rdy_mode = 0;
    wv_mode = 1;
    c0 = cyc;
    w0 = wseq;
    run_line(100, 1'b1, 640);
    exp_disp = !exp_disp;
    win = t_done - t_trig + 1;
    checks++;
    if (wseq - w0 != (cyc - c0) - win) begin
      errors++;
      $display("FAIL hold_grants got %0d want %0d",
               wseq - w0, (cyc - c0) - win);
    end
    checks++;
    if (rd_q.size() != 640) begin
      errors++;
      $display("FAIL hold_reads got %0d want 640", rd_q.size());
    end
    checks++;
    if (wr_q.size() != wseq - w0) begin
      errors++;
      $display("FAIL hold_writes got %0d want %0d", wr_q.size(), wseq - w0);
    end
    for (int i = 0; i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== {wa_fn(w0 + i), wd_fn(w0 + i)}) begin
        errors++;
        $display("FAIL hold_wr_order i=%0d got %h want %h",
                 i, wr_q[i], {wa_fn(w0 + i), wd_fn(w0 + i)});
      end
    end
  endtask

  task automatic test_underrun();
    int base;
    bit bank;
    clear();
    rdy_mode = 2;
    wv_mode = 0;
    base = 201 * 640;
    bank = !exp_disp;
    run_line(200, 1'b0, 0);
    exp_disp = !exp_disp;
    exp_und = 1;
    rdy_mode = 0;
    sx = 10'd0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (rd_q.size() == 0 || rd_q.size() >= 640) begin
      errors++;
      $display("FAIL und_reads got %0d want 1..639", rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== 19'(base + i)) begin
        errors++;
        $display("FAIL und_addr i=%0d got %0d want %0d",
                 i, rd_q[i], base + i);
      end
    end
    checks++;
    if (lbw_q.size() != lb_at_swap || lb_at_swap > rd_q.size()) begin
      errors++;
      $display("FAIL und_drain_lb got %0d want %0d", lbw_q.size(), lb_at_swap);
    end
    for (int i = 0; i < lbw_q.size(); i++) begin
      checks++;
      if (lbw_q[i] !== {bank, 10'(i), rd_fn(19'(base + i))}) begin
        errors++;
        $display("FAIL und_lb i=%0d got %h want %h", i, lbw_q[i],
                 {bank, 10'(i), rd_fn(19'(base + i))});
      end
    end
    checks++;
    if ({wr_ready, disp_bank, underrun} !== {1'b1, exp_disp, 1'b1}) begin
      errors++;
      $display("FAIL und_flags got %b want %b",
               {wr_ready, disp_bank, underrun}, {1'b1, exp_disp, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    int b;
    int n;
    clear();
    rdy_mode = 0;
    wv_mode = 0;
    sy = 10'd300;
    for (int x = 636; x <= 640; x++) begin
      sx = 10'(x);
      step();
    end
    sx = 10'd700;
    b = 0;
    while (rd_q.size() < 300 && b < 1000) begin
      step();
      b++;
    end
    checks++;
    if (rd_q.size() != 300) begin
      errors++;
      $display("FAIL rstmid_issue got %0d want 300", rd_q.size());
    end
    rst = 1'b1;
    rdy_mode = 3;
    step();
    rst = 1'b0;
    exp_disp = 0;
    exp_und = 0;
    n = lbw_q.size();
    checks++;
    if ({mem_req, mem_we, wr_ready, lb_we, lb_bank, disp_bank, underrun}
        !== 7'd0) begin
      errors++;
      $display("FAIL rstmid_ctl got %b want 0000000",
               {mem_req, mem_we, wr_ready, lb_we, lb_bank, disp_bank, underrun});
    end
    checks++;
    if ({mem_addr, mem_wdata, lb_addr, lb_wdata} !== 61'd0) begin
      errors++;
      $display("FAIL rstmid_data got %h want 0",
               {mem_addr, mem_wdata, lb_addr, lb_wdata});
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (lbw_q.size() != n) begin
      errors++;
      $display("FAIL rstmid_late_lb got %0d want %0d", lbw_q.size(), n);
    end
  endtask

  initial begin
    rst = 1'b1;
    sx = '0;
    sy = '0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk_pix);
    test_reset();
    test_fetch(524, 0, 0);
    test_fetch(9, 0, 2);
    test_fetch($urandom_range(0, 478), 1, 2);
    test_blank();
    test_writer_hold();
    test_underrun();
    test_fetch(201, 1, 2);
    test_reset_mid();
    test_fetch(524, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_line_scheduler.md
Name: fb_line_scheduler

Overview:
- Memory-side controller for the 640x480p60 scanout path. It sits between the display timing generator (which supplies sx/sy) and a single-port framebuffer memory.
- During each horizontal blanking interval it prefetches the next active line into one bank of a ping-pong line buffer. It swaps banks at line end.
- Outside fetch bursts it grants the memory to a lower-priority pixel writer (drawing engine) through a valid/ready port.

Parameters:
- H_RES, 800, total pixels per line including blanking
- V_RES, 525, total lines per frame
- X_RES, 640, active pixels per line (words fetched per line)
- Y_RES, 480, active lines
- DW, 16, pixel/memory data width
- AW, 19, framebuffer word address width (X_RES*Y_RES = 307200 < 2^19)

Ports:
- clk_pix  in  1  pixel clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- sx  in  10  horizontal position from timing generator
- sy  in  10  vertical position from timing generator
- wr_valid  in  1  writer request
- wr_ready  out  1  writer accepted this cycle (wr_valid & wr_ready)
- wr_addr  in  AW  writer word address
- wr_data  in  DW  writer data
- mem_req  out  1  memory command valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  memory word address
- mem_wdata  out  DW  write data
- mem_ready  in  1  memory accepts command when mem_req & mem_ready
- mem_rvalid  in  1  read data return, in order, latency >= 1
- mem_rdata  in  DW  read data
- lb_we  out  1  line buffer write strobe
- lb_bank  out  1  bank written (always ~disp_bank)
- lb_addr  out  10  line buffer word index 0..X_RES-1
- lb_wdata  out  DW  line buffer data (mem_rdata registered pass-through allowed: combinational)
- disp_bank  out  1  bank the scanout reads on the current line
- underrun  out  1  sticky: a fetch was not complete at bank swap

Behaviour:
- Reset values: all outputs 0; state IDLE; issue_cnt = 0, rcv_cnt = 0; disp_bank = 0; underrun = 0.
- next_y = (sy == V_RES-1) ? 0 : sy+1. A line is needed when next_y < Y_RES.
- Trigger: fetch_start = (sx == X_RES) & needed. base = next_y*X_RES, computed as (next_y<<9)+(next_y<<7) for X_RES = 640, width AW. Other X_RES values use a constant multiply.
- States:
  - IDLE:
    - On fetch_start, go to FETCH; base is latched and counters are cleared.
    - Otherwise wr_ready = wr_valid-independent (mem_ready & ~fetch_start). mem_req = wr_valid, mem_we = 1, addr/data from the wr_* inputs.
  - FETCH:
    - mem_req = 1, mem_we = 0, mem_addr = base + issue_cnt.
    - issue_cnt increments on each accepted command. After the X_RES-th accept, go to WAIT.
    - wr_ready = 0.
  - WAIT: mem_req = 0. When rcv_cnt reaches X_RES, return to IDLE.
  - DRAIN (abort): mem_req = 0, lb_we = 0. When rcv_cnt == issue_cnt, go to IDLE.
- Read returns: in FETCH/WAIT, each mem_rvalid drives lb_we = 1, lb_addr = rcv_cnt, lb_wdata = mem_rdata, lb_bank = ~disp_bank, and increments rcv_cnt. In DRAIN, returns are counted only.
- Bank swap: at sx == H_RES-1 with needed = 1, disp_bank toggles.
  - If state is FETCH or WAIT at that cycle: underrun <= 1 and the state goes to DRAIN.
  - The swap still occurs, so the display shows a stale/partial line rather than stalling.
- If fetch_start arrives while in DRAIN: underrun <= 1, the fetch for that line is skipped, and state is unaffected.
- Writer is never granted in the cycle fetch_start is asserted, nor in FETCH/WAIT/DRAIN. Fetch has strict priority.
- No prefetch is issued during the fetch window preceding a blank line. Line 0 is fetched during line V_RES-1 (sx = 640).
- Reset mid-burst returns to IDLE immediately. Memory returns in flight after reset are ignored: rvalid in IDLE is dropped.
- underrun clears only on rst.
- Counters are 10 bits; no wrap within a line (X_RES <= 1023).

Test Plan:
- Reset, then free-run timing with mem_ready = 1 and rvalid latency 2 → at sy = 524, sx = 640: 640 reads at addr 0..639. lb_we fills bank 1 at idx 0..639. disp_bank toggles to 1 at sy = 524, sx = 799. underrun = 0.
- sy = 9, sx = 640 → reads base 6400 (10*640); the last lb_addr written is 639 with lb_bank = ~disp_bank.
- sy = 479..523 (next line blank) → no mem reads issued, disp_bank unchanged, writer granted every cycle with wr_valid = 1.
- wr_valid held high across sx = 640 → wr_ready = 0 from the trigger cycle until WAIT completes. Writes in memory resume with no lost or duplicated wr_addr.
- mem_ready toggling 1-in-8 → fetch is incomplete at sx = 799. underrun = 1, DRAIN absorbs exactly issue_cnt returns, and the next line fetches normally. underrun stays 1.
- Assert rst for 1 cycle mid-FETCH (issue_cnt = 300) → all outputs 0 next cycle. Late rvalid produces no lb_we. Normal operation resumes next frame.
